ex_mem_stage: RTL

//  EX->MEM pipeline stage: captures the ALU result, zero flag, store data and

---
 rtl/ex_mem_stage.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/ex_mem_stage.sv
// EX->MEM pipeline register built as a 2-entry skid buffer with branch resolution.
// Optional macro FWD_BYPASS_EN adds the EX operand-forwarding outputs.
module ex_mem_stage #(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_W-1:0]     alu_result,
    input  logic                  zero,
    input  logic [DATA_W-1:0]     store_data,
    input  logic [REG_ADDR_W-1:0] rd_addr,
    input  logic                  reg_write,
    input  logic                  mem_read,
    input  logic                  mem_write,
    input  logic                  mem_to_reg,
    input  logic                  branch,
    input  logic [DATA_W-1:0]     branch_target,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_W-1:0]     m_alu_result,
    output logic [DATA_W-1:0]     m_store_data,
    output logic [REG_ADDR_W-1:0] m_rd_addr,
    output logic                  m_reg_write,
    output logic                  m_mem_read,
    output logic                  m_mem_write,
    output logic                  m_mem_to_reg,
    output logic                  branch_taken,
    output logic [DATA_W-1:0]     pc_target
`ifdef FWD_BYPASS_EN
    ,
    output logic                  fwd_valid,
    output logic [REG_ADDR_W-1:0] fwd_rd,
    output logic [DATA_W-1:0]     fwd_data
`endif
);

    typedef struct packed {
        logic [DATA_W-1:0]     alu_result;
        logic [DATA_W-1:0]     store_data;
        logic [REG_ADDR_W-1:0] rd_addr;
        logic                  reg_write;
        logic                  mem_read;
        logic                  mem_write;
        logic                  mem_to_reg;
    } payload_t;

    // Bit 0 is main_v, bit 1 is skid_v, so both handshake outputs come straight off flops.
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b01,
        FULL  = 2'b11
    } state_t;

    state_t   state_q, state_d;
    payload_t main_q, skid_q, main_d, skid_d, beat;
    logic     accept, emit;
    logic     taken_d;

    assign in_ready  = ~state_q[1];
    assign out_valid = state_q[0];
    assign accept    = in_valid & in_ready & ~flush;
    assign emit      = out_valid & out_ready;

    // Capture sanitising: x0 is never written, and read wins over write.
    always_comb begin
        beat.alu_result = alu_result;
        beat.store_data = store_data;
        beat.rd_addr    = rd_addr;
        beat.reg_write  = reg_write & (rd_addr != '0);
        beat.mem_read   = mem_read;
        beat.mem_write  = mem_write & ~mem_read;
        beat.mem_to_reg = mem_to_reg;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= EMPTY;
            main_q       <= '0;
            skid_q       <= '0;
            branch_taken <= 1'b0;
            pc_target    <= '0;
        end else begin
            state_q      <= state_d;
            main_q       <= main_d;
            skid_q       <= skid_d;
            branch_taken <= taken_d;
            if (taken_d) begin
                pc_target <= branch_target;
            end
        end
    end

    // Next-state and entry-load decode; flush overrides any transition.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        taken_d = accept & branch & zero;
        unique case (state_q)
            EMPTY: begin
                if (accept) begin
                    main_d  = beat;
                    state_d = ONE;
                end
            end
            ONE: begin
                if (accept && emit) begin
                    main_d = beat;
                end else if (accept) begin
                    skid_d  = beat;
                    state_d = FULL;
                end else if (emit) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                if (emit) begin
                    main_d  = skid_q;
                    state_d = ONE;
                end
            end
            default: state_d = EMPTY;
        endcase
        if (flush) begin
            state_d = EMPTY;
        end
    end

    assign m_alu_result = main_q.alu_result;
    assign m_store_data = main_q.store_data;
    assign m_rd_addr    = main_q.rd_addr;
    assign m_reg_write  = main_q.reg_write;
    assign m_mem_read   = main_q.mem_read;
    assign m_mem_write  = main_q.mem_write;
    assign m_mem_to_reg = main_q.mem_to_reg;

`ifdef FWD_BYPASS_EN
    assign fwd_valid = state_q[0] & main_q.reg_write & ~main_q.mem_to_reg;
    assign fwd_rd    = main_q.rd_addr;
    assign fwd_data  = main_q.alu_result;
`endif

endmodule
